// File: rtl/debounce_pulse_pkg.sv
// Shared definitions for the input-conditioning blocks: debouncer state
// encodings and a small state-classification helper.
package debounce_pulse_pkg;

  // 2-bit state encodings, fixed so later conditioning blocks agree on them.
  typedef enum logic [1:0] {
    ST_IDLE_LO = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_IDLE_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } db_state_e;

  // True while a candidate transition is being qualified.
  function automatic logic is_wait(input db_state_e st);
    return (st == ST_WAIT_HI) || (st == ST_WAIT_LO);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops clear to 0 on the synchronous active-high clear.
module sync_2ff (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next values simply shift the input down the chain.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchroniser flops; clear wins over the shift.
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Debouncer: synchronises a bouncing raw input, qualifies each candidate
// level change with a stability counter and emits a clean registered level
// plus single-cycle rise/fall pulses. All outputs come straight from flops.
module debounce_pulse
  import debounce_pulse_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s2;

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_2ff u_sync (
    .clk   (clk),
    .clear (clear),
    .d     (din),
    .q     (s2)
  );

  // Next-state, counter and output computation; pulses default low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_IDLE_LO: begin
        level_d = 1'b0;
        if (s2) begin
          state_d = ST_WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_HI: begin
        if (!s2) begin
          state_d = ST_IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_IDLE_HI: begin
        level_d = 1'b1;
        if (!s2) begin
          state_d = ST_WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_LO: begin
        if (s2) begin
          state_d = ST_IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    busy_d = is_wait(state_d);
  end

  // FSM, counter and registered outputs; clear discards any pending change.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

endmodule
